// File: rtl/rs_ctrl_pkg.sv
// Shared definitions for the RS latch sequencer: state encoding and the
// helper that gives the q/qb pair an operation is expected to produce.
package rs_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        DRIVE = ST_DRIVE,
        CHECK = ST_CHECK,
        GAP   = ST_GAP
    } state_e;

    // {q, qb} the latch should show once a set (1) or clear (0) has landed
    function automatic logic [1:0] expected_qqb(input logic want_set);
        return {want_set, ~want_set};
    endfunction

endpackage

// File: rtl/rs_ctrl_timer.sv
// Loadable saturating down-counter shared by the DRIVE and CHECK phases.
module rs_ctrl_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] count_r;

    // Count register: load wins over decrement, decrement stops at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/rs_latch_ctrl.sv
// Sequencer owning the s/r inputs of a NOR RS latch: arbitrates set/clear
// requests, issues timed exclusive pulses and verifies the q/qb feedback.
module rs_latch_ctrl
    import rs_ctrl_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_req,
    input  logic clr_req,
    input  logic q,
    input  logic qb,
    output logic s,
    output logic r,
    output logic busy,
    output logic done,
    output logic err,
    output logic grant_set
);

    localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT - 1);

    state_e           state_r;
    logic             last_set_r;
    logic             pick_set_s;
    logic             any_req_s;
    logic             idle_match_s;
    logic             op_match_s;
    logic             q_eq_s;
    logic             timer_load_s;
    logic             timer_dec_s;
    logic [CNT_W-1:0] timer_val_s;
    logic             timer_exp_s;

    // Arbitration and feedback comparisons
    always_comb begin
        any_req_s    = set_req | clr_req;
        // on a tie, serve whichever type did not go last
        pick_set_s   = set_req & (~clr_req | ~last_set_r);
        idle_match_s = ({q, qb} == expected_qqb(pick_set_s));
        op_match_s   = ({q, qb} == expected_qqb(grant_set));
        q_eq_s       = (q == qb);
    end

    // Timer load/decrement control derived from the current state
    always_comb begin
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;
        timer_val_s  = PULSE_LOAD;
        case (state_r)
            IDLE: begin
                if (any_req_s && !idle_match_s) begin
                    timer_load_s = 1'b1;
                end else begin
                    timer_load_s = 1'b0;
                end
            end
            DRIVE: begin
                if (timer_exp_s) begin
                    if (!op_match_s && !q_eq_s) begin
                        timer_load_s = 1'b1;
                        timer_val_s  = TIMEOUT_LOAD;
                    end else begin
                        timer_load_s = 1'b0;
                    end
                end else begin
                    timer_dec_s = 1'b1;
                end
            end
            CHECK: begin
                if (!timer_exp_s) begin
                    timer_dec_s = 1'b1;
                end else begin
                    timer_dec_s = 1'b0;
                end
            end
            default: begin
                timer_load_s = 1'b0;
            end
        endcase
    end

    rs_ctrl_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_s),
        .dec      (timer_dec_s),
        .load_val (timer_val_s),
        .expired  (timer_exp_s)
    );

    // Main FSM with registered latch drives and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            last_set_r <= 1'b0;
            s          <= 1'b0;
            r          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            grant_set  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_req_s) begin
                        grant_set <= pick_set_s;
                        busy      <= 1'b1;
                        if (idle_match_s) begin
                            done    <= 1'b1;
                            state_r <= GAP;
                        end else begin
                            s       <= pick_set_s;
                            r       <= ~pick_set_s;
                            state_r <= DRIVE;
                        end
                    end
                end
                DRIVE: begin
                    // the expiry edge doubles as the first feedback check
                    if (timer_exp_s) begin
                        s <= 1'b0;
                        r <= 1'b0;
                        if (op_match_s) begin
                            done    <= 1'b1;
                            state_r <= GAP;
                        end else if (q_eq_s) begin
                            err     <= 1'b1;
                            state_r <= GAP;
                        end else begin
                            state_r <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (op_match_s) begin
                        done    <= 1'b1;
                        state_r <= GAP;
                    end else if (q_eq_s || timer_exp_s) begin
                        err     <= 1'b1;
                        state_r <= GAP;
                    end
                end
                GAP: begin
                    last_set_r <= grant_set;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    s       <= 1'b0;
                    r       <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_latch_ctrl.sv
// Scoreboard bench for rs_latch_ctrl closing the loop through a behavioural
// nor_rs latch with optional feedback override for fault scenarios.
module tb_rs_latch_ctrl;

    localparam int P  = 2;
    localparam int T  = 8;
    localparam int CW = 4;

    typedef struct {
        logic is_err;
        logic grant;
        int   due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_req = 1'b0;
    logic clr_req = 1'b0;
    logic q, qb, s, r, busy, done, err, grant_set;
    logic q_lat = 1'b0;
    logic qb_lat = 1'b1;
    logic ovr_en = 1'b0;
    logic ovr_q = 1'b0;
    logic ovr_qb = 1'b0;
    logic q_m = 1'b0;
    logic last_set_m = 1'b0;
    logic g1, g2;
    int   d1, n_ev, t_end;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // nor_rs latch model, settling mid-cycle after s/r change
    always @(negedge clk) begin
        if (s && !r) begin
            q_lat  <= 1'b1;
            qb_lat <= 1'b0;
        end else if (r && !s) begin
            q_lat  <= 1'b0;
            qb_lat <= 1'b1;
        end
    end

    assign q  = ovr_en ? ovr_q  : q_lat;
    assign qb = ovr_en ? ovr_qb : qb_lat;

    rs_latch_ctrl #(.PULSE_W(P), .TIMEOUT(T), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_req   (set_req),
        .clr_req   (clr_req),
        .q         (q),
        .qb        (qb),
        .s         (s),
        .r         (r),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .grant_set (grant_set)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push_exp(input logic is_err, input logic grant, input int due);
        exp_t e;
        e.is_err = is_err;
        e.grant  = grant;
        e.due    = due;
        sb.push_back(e);
    endtask

    // Completion monitor: every done/err is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n) check("s_and_r", 32'(s & r), 32'd0);
        if (done || err) begin
            if (sb.size() == 0) begin
                check("unexpected_event", 32'({done, err}), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("event_kind_err", 32'(err), 32'(mon_e.is_err));
                check("event_kind_done", 32'(done), 32'(!mon_e.is_err));
                check("event_grant", 32'(grant_set), 32'(mon_e.grant));
                check("event_cycle", 32'(cyc), 32'(mon_e.due));
                if (done) check("done_qqb", 32'({q, qb}), 32'({mon_e.grant, ~mon_e.grant}));
            end
        end
    end

    // mode 0: healthy latch, 1: feedback forced q=qb=0, 2: feedback stuck at old value
    task automatic run_op(input logic sreq, input logic creq, input int mode);
        logic g, skip, seen;
        int   d, s_cnt, r_cnt;
        g    = (sreq && creq) ? !last_set_m : sreq;
        skip = (mode == 0) && (q_m == g);
        d    = skip ? 1 : ((mode == 2) ? 1 + P + T : 1 + P);
        push_exp(mode != 0, g, cyc + d);
        ovr_en  = (mode != 0);
        ovr_q   = (mode == 2) ? q_m : 1'b0;
        ovr_qb  = (mode == 2) ? !q_m : 1'b0;
        set_req = sreq;
        clr_req = creq;
        s_cnt = 0;
        r_cnt = 0;
        seen  = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (s) s_cnt++;
            if (r) r_cnt++;
            seen = done | err;
        end
        check("event_seen", 32'(seen), 32'd1);
        check("busy_at_event", 32'(busy), 32'd1);
        set_req = 1'b0;
        clr_req = 1'b0;
        ovr_en  = 1'b0;
        check("s_pulse_len", s_cnt, (!skip && g) ? P : 0);
        check("r_pulse_len", r_cnt, (!skip && !g) ? P : 0);
        q_m        = g;
        last_set_m = g;
        @(posedge clk);
        #1;
        check("busy_after_gap", 32'(busy), 32'd0);
        check("q_final", 32'({q, qb}), 32'({g, ~g}));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_s", 32'(s), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_grant", 32'(grant_set), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(1'b1, 1'b0, 0);
        run_op(1'b0, 1'b1, 0);

        // both requests held across two services
        g1 = !last_set_m;
        d1 = (q_m == g1) ? 1 : 1 + P;
        g2 = !g1;
        push_exp(1'b0, g1, cyc + d1);
        push_exp(1'b0, g2, cyc + d1 + 1 + 1 + P);
        set_req = 1'b1;
        clr_req = 1'b1;
        n_ev = 0;
        for (int i = 0; i < 60 && n_ev < 2; i++) begin
            @(posedge clk);
            #1;
            if (done) n_ev++;
        end
        set_req = 1'b0;
        clr_req = 1'b0;
        check("tie_events", n_ev, 2);
        q_m        = g2;
        last_set_m = g2;
        @(posedge clk);
        #1;
        check("tie_busy_end", 32'(busy), 32'd0);

        run_op(1'b1, 1'b0, 0);
        run_op(1'b1, 1'b0, 0);
        run_op(1'b0, 1'b1, 1);
        run_op(1'b1, 1'b0, 2);
        run_op(1'b0, 1'b1, 0);

        // reset asserted while s is being driven
        set_req = 1'b1;
        @(posedge clk);
        #1;
        check("s_before_rst", 32'(s), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_s", 32'(s), 32'd0);
        check("rst_mid_r", 32'(r), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_done", 32'(done), 32'd0);
        check("rst_mid_err", 32'(err), 32'd0);
        last_set_m = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run_op(1'b1, 1'b0, 0);

        // random request stream
        t_end = cyc + 2000;
        while (cyc < t_end) begin
            int v;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            v = $urandom_range(1, 3);
            run_op(v[0], v[1], 0);
        end

        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
